// File: rtl/bsg_manycore_link_test_responder.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_link_test_responder
// Purpose  : Far-end responder for manycore link test traffic. It serves
//            load/store requests against a small local word memory. Each
//            request gets exactly one response, in order, through a 2-entry
//            response FIFO. It also keeps traffic counters and a sticky
//            error flag.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_manycore_link_test_responder #(
   parameter int addr_width_p   = 28,
   parameter int data_width_p   = 32,
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7,
   parameter int lg_mem_els_p   = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      en_i,
   input  logic                      req_v_i,
   output logic                      req_ready_o,
   input  logic [1:0]                req_op_i,
   input  logic [addr_width_p-1:0]   req_addr_i,
   input  logic [data_width_p-1:0]   req_data_i,
   input  logic [4:0]                req_reg_id_i,
   input  logic [x_cord_width_p-1:0] req_src_x_i,
   input  logic [y_cord_width_p-1:0] req_src_y_i,
   output logic                      resp_v_o,
   input  logic                      resp_yumi_i,
   output logic [1:0]                resp_type_o,
   output logic [data_width_p-1:0]   resp_data_o,
   output logic [4:0]                resp_reg_id_o,
   output logic [x_cord_width_p-1:0] resp_dest_x_o,
   output logic [y_cord_width_p-1:0] resp_dest_y_o,
   output logic [31:0]               received_o,
   output logic [31:0]               sent_o,
   output logic                      error_o
);

   localparam int         MEM_ELS    = 1 << lg_mem_els_p;
   localparam logic [1:0] OP_LOAD    = 2'd0;
   localparam logic [1:0] OP_STORE   = 2'd1;
   localparam logic [1:0] RESP_LOAD  = 2'd0;
   localparam logic [1:0] RESP_STORE = 2'd1;
   localparam logic [1:0] RESP_ERR   = 2'd2;

   typedef struct packed {
      logic [1:0]                typ;
      logic [data_width_p-1:0]   data;
      logic [4:0]                reg_id;
      logic [x_cord_width_p-1:0] dest_x;
      logic [y_cord_width_p-1:0] dest_y;
   } resp_t;

   logic [data_width_p-1:0] mem_q [MEM_ELS];
   logic [data_width_p-1:0] mem_d [MEM_ELS];
   resp_t                   fifo_q [2];
   resp_t                   fifo_d [2];
   logic                    wr_ptr_q, wr_ptr_d;
   logic                    rd_ptr_q, rd_ptr_d;
   logic [1:0]              count_q, count_d;
   logic [31:0]             received_q, received_d;
   logic [31:0]             sent_q, sent_d;
   logic                    error_q, error_d;

   logic                    full, empty, accept, deq, addr_ok;
   logic [lg_mem_els_p-1:0] idx;
   resp_t                   new_resp, head;

   // Handshake: ready depends only on held state and enable; reset also masks it
   always_comb begin
      full        = (count_q == 2'd2);
      empty       = (count_q == 2'd0);
      req_ready_o = en_i & ~full & reset_n_i;
      accept      = req_v_i & req_ready_o;
      deq         = resp_yumi_i & ~empty;
   end

   // Request decode into the response that will be enqueued on accept
   always_comb begin
      addr_ok         = (req_addr_i < addr_width_p'(MEM_ELS));
      idx             = req_addr_i[lg_mem_els_p-1:0];
      new_resp        = '0;
      new_resp.reg_id = req_reg_id_i;
      new_resp.dest_x = req_src_x_i;
      new_resp.dest_y = req_src_y_i;
      if (addr_ok && req_op_i == OP_LOAD) begin
         new_resp.typ  = RESP_LOAD;
         new_resp.data = mem_q[idx];
      end else if (addr_ok && req_op_i == OP_STORE) begin
         new_resp.typ  = RESP_STORE;
      end else begin
         new_resp.typ  = RESP_ERR;
      end
   end

   // Next-state: memory write, FIFO push/pop, counters and sticky error
   always_comb begin
      mem_d      = mem_q;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      received_d = received_q;
      sent_d     = sent_q;
      error_d    = error_q;
      if (accept) begin
         fifo_d[wr_ptr_q] = new_resp;
         wr_ptr_d         = ~wr_ptr_q;
         received_d       = received_q + 32'd1;
         if (new_resp.typ == RESP_STORE) mem_d[idx] = req_data_i;
         if (new_resp.typ == RESP_ERR)   error_d    = 1'b1;
      end
      if (deq) rd_ptr_d = ~rd_ptr_q;
      if (resp_yumi_i) begin
         sent_d = sent_q + 32'd1;
         // consuming a response that is not there is a protocol violation
         if (empty) error_d = 1'b1;
      end
      count_d = count_q + {1'b0, accept} - {1'b0, deq};
   end

   // State registers; reset discards buffered responses and clears memory
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < MEM_ELS; i++) mem_q[i] <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         received_q <= 32'd0;
         sent_q     <= 32'd0;
         error_q    <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         received_q <= received_d;
         sent_q     <= sent_d;
         error_q    <= error_d;
      end
   end

   // Response fields come straight from the registered FIFO head entry
   always_comb begin
      head          = fifo_q[rd_ptr_q];
      resp_v_o      = ~empty;
      resp_type_o   = head.typ;
      resp_data_o   = head.data;
      resp_reg_id_o = head.reg_id;
      resp_dest_x_o = head.dest_x;
      resp_dest_y_o = head.dest_y;
      received_o    = received_q;
      sent_o        = sent_q;
      error_o       = error_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_link_test_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_link_test_responder
// Purpose  : Directed plus random self-checking bench for the link test
//            responder, using a response scoreboard and a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_manycore_link_test_responder;

   logic        clk = 1'b0;
   logic        reset_n_i;
   logic        en_i, req_v_i, req_ready_o, resp_v_o, resp_yumi_i, error_o;
   logic [1:0]  req_op_i, resp_type_o;
   logic [27:0] req_addr_i;
   logic [31:0] req_data_i, resp_data_o, received_o, sent_o;
   logic [4:0]  req_reg_id_i, resp_reg_id_o;
   logic [6:0]  req_src_x_i, req_src_y_i, resp_dest_x_o, resp_dest_y_o;

   always #5 clk = ~clk;

   bsg_manycore_link_test_responder dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .en_i(en_i),
      .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_reg_id_i(req_reg_id_i),
      .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
      .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_type_o(resp_type_o),
      .resp_data_o(resp_data_o), .resp_reg_id_o(resp_reg_id_o),
      .resp_dest_x_o(resp_dest_x_o), .resp_dest_y_o(resp_dest_y_o),
      .received_o(received_o), .sent_o(sent_o), .error_o(error_o)
   );

   typedef struct packed {
      logic [1:0]  t;
      logic [31:0] d;
      logic [4:0]  tag;
      logic [6:0]  x;
      logic [6:0]  y;
   } rsp_t;

   rsp_t        sb [$];
   logic [31:0] mdl_mem [16];
   int          n_rcv, n_snt;
   bit          mdl_err;
   int          errors = 0;
   int          checks = 0;
   bit          acc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered and left just after a falling edge
   task automatic cycle(input bit v, input logic [1:0] op, input logic [27:0] addr,
                        input logic [31:0] data, input logic [4:0] tag,
                        input logic [6:0] sx, input logic [6:0] sy,
                        input bit yumi, output bit accepted);
      rsp_t e, o;
      bit   exp_ready;
      req_v_i = v; req_op_i = op; req_addr_i = addr; req_data_i = data;
      req_reg_id_i = tag; req_src_x_i = sx; req_src_y_i = sy; resp_yumi_i = yumi;
      #1;
      exp_ready = en_i && (sb.size() < 2);
      check("req_ready", 64'(req_ready_o), 64'(exp_ready));
      check("resp_v", 64'(resp_v_o), 64'(sb.size() > 0));
      if (yumi) begin
         n_snt++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            o = {resp_type_o, resp_data_o, resp_reg_id_o, resp_dest_x_o, resp_dest_y_o};
            check("resp_fields", 64'(o), 64'(e));
         end else begin
            mdl_err = 1'b1;
         end
      end
      accepted = v && exp_ready;
      if (accepted) begin
         n_rcv++;
         e = '{t: 2'd2, d: 32'd0, tag: tag, x: sx, y: sy};
         if (op == 2'd0 && addr < 28'd16) begin
            e.t = 2'd0;
            e.d = mdl_mem[addr[3:0]];
         end else if (op == 2'd1 && addr < 28'd16) begin
            e.t = 2'd1;
            mdl_mem[addr[3:0]] = data;
         end else begin
            mdl_err = 1'b1;
         end
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      check("received", 64'(received_o), 64'(n_rcv));
      check("sent", 64'(sent_o), 64'(n_snt));
      check("error", 64'(error_o), 64'(mdl_err));
   endtask

   task automatic idle(input bit yumi);
      bit a;
      cycle(1'b0, 2'd0, 28'd0, 32'd0, 5'd0, 7'd0, 7'd0, yumi, a);
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         idle(1'b1);
      end
      check("drain_empty", 64'(resp_v_o), 64'(0));
   endtask

   // Assert reset shortly after a falling edge, check async effect, then release
   task automatic apply_reset();
      #2 reset_n_i = 1'b0;
      #1;
      check("rst_resp_v_async", 64'(resp_v_o), 64'(0));
      sb.delete();
      for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
      n_rcv = 0; n_snt = 0; mdl_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready_o), 64'(0));
      check("rst_fields", 64'({resp_type_o, resp_data_o, resp_reg_id_o, resp_dest_x_o, resp_dest_y_o}), 64'(0));
      check("rst_received", 64'(received_o), 64'(0));
      check("rst_sent", 64'(sent_o), 64'(0));
      check("rst_error", 64'(error_o), 64'(0));
      reset_n_i = 1'b1;
   endtask

   initial begin
      int cyc;
      reset_n_i = 1'b0; en_i = 1'b0; req_v_i = 1'b1; req_op_i = 2'd0;
      req_addr_i = '0; req_data_i = '0; req_reg_id_i = '0;
      req_src_x_i = '0; req_src_y_i = '0; resp_yumi_i = 1'b0;

      // Reset with en_i=0 and a pending request; nothing accepted after release
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 28'd1, 32'd0, 5'd1, 7'd1, 7'd1, 1'b0, acc);

      // Store then back-to-back load of the same address
      en_i = 1'b1;
      cycle(1'b1, 2'd1, 28'd3, 32'hDEADBEEF, 5'd5, 7'd9, 7'd4, 1'b0, acc);
      cycle(1'b1, 2'd0, 28'd3, 32'd0,        5'd6, 7'd9, 7'd4, 1'b1, acc);
      idle(1'b1);
      check("t2_received", 64'(received_o), 64'(2));
      check("t2_sent", 64'(sent_o), 64'(2));

      // Full FIFO back-pressure: third load waits for one yumi
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd7, 7'd2, 7'd3, 1'b0, acc);
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd8, 7'd2, 7'd3, 1'b0, acc);
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd9, 7'd2, 7'd3, 1'b0, acc);
      check("t3_third_blocked", 64'(req_ready_o), 64'(0));
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd9, 7'd2, 7'd3, 1'b1, acc);
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd9, 7'd2, 7'd3, 1'b0, acc);
      drain();

      // Out of range address and illegal op; memory must remain intact
      cycle(1'b1, 2'd0, 28'd16, 32'd0,         5'd10, 7'd1, 7'd2, 1'b0, acc);
      cycle(1'b1, 2'd3, 28'd3,  32'h12345678,  5'd11, 7'd1, 7'd2, 1'b1, acc);
      drain();
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd12, 7'd1, 7'd2, 1'b0, acc);
      drain();
      check("t4_error_sticky", 64'(error_o), 64'(1));

      // Reset with two responses buffered; stored data must be gone afterwards
      cycle(1'b1, 2'd1, 28'd5, 32'hCAFEF00D, 5'd13, 7'd3, 7'd3, 1'b0, acc);
      drain();
      cycle(1'b1, 2'd0, 28'd5, 32'd0, 5'd14, 7'd3, 7'd3, 1'b0, acc);
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd15, 7'd3, 7'd3, 1'b0, acc);
      check("t6_two_buffered", 64'(req_ready_o), 64'(0));
      apply_reset();
      cycle(1'b1, 2'd0, 28'd3, 32'd0, 5'd16, 7'd4, 7'd4, 1'b0, acc);
      cycle(1'b1, 2'd0, 28'd5, 32'd0, 5'd17, 7'd4, 7'd4, 1'b1, acc);
      drain();

      // Random continuous traffic with yumi gaps, then disable and drain
      apply_reset();
      en_i = 1'b1;
      cyc = 0;
      while (n_rcv < 1000 && cyc < 20000) begin
         cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 1)), 28'($urandom_range(0, 15)),
               $urandom, 5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)),
               7'($urandom_range(0, 127)), (sb.size() > 0) && ($urandom_range(0, 2) != 0), acc);
         cyc++;
      end
      check("t5_budget", 64'(n_rcv), 64'(1000));
      en_i = 1'b0;
      drain();
      check("t5_received", 64'(received_o), 64'(1000));
      check("t5_sent", 64'(sent_o), 64'(1000));
      check("t5_error", 64'(error_o), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bsg_manycore_link_test_responder.md
Name: bsg_manycore_link_test_responder

Overview:
- Responder endpoint for the manycore link test traffic produced by the link test node. It sits behind the SDR link pair on the gateway side, at the far end of the chip's horizontal link.
- Accepts request packets as flat fields: load/store into a small local word memory.
- Returns one response packet per request, addressed to the request's source.
- Keeps sent/received counters and a sticky error flag so the bench checks results the same way it does for test nodes.

Parameters:
- addr_width_p, 28, request address width
- data_width_p, 32, data word width
- x_cord_width_p, 7, x coordinate width
- y_cord_width_p, 7, y coordinate width
- lg_mem_els_p, 4, log2 of local memory words (16 words)

Ports:
- clk_i  in  1  core clock
- reset_n_i  in  1  asynchronous active-low reset
- en_i  in  1  accept enable; 0 forces req_ready_o=0
- req_v_i  in  1  request valid
- req_ready_o  out  1  request ready (ready-valid; accept = req_v_i & req_ready_o)
- req_op_i  in  2  0=load, 1=store, 2/3=illegal
- req_addr_i  in  addr_width_p  word address
- req_data_i  in  data_width_p  store data
- req_reg_id_i  in  5  tag echoed in response
- req_src_x_i  in  x_cord_width_p  requester x
- req_src_y_i  in  y_cord_width_p  requester y
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  response consumed (only legal when resp_v_o=1)
- resp_type_o  out  2  0=load data, 1=store credit, 2=error
- resp_data_o  out  data_width_p  load data; 0 otherwise
- resp_reg_id_o  out  5  echoed tag
- resp_dest_x_o  out  x_cord_width_p  = request src_x
- resp_dest_y_o  out  y_cord_width_p  = request src_y
- received_o  out  32  accepted request count
- sent_o  out  32  consumed response count
- error_o  out  1  sticky error flag

Behaviour:
- Reset (reset_n_i=0, asynchronous): memory cleared to 0; response FIFO empty.
  - Outputs at reset: resp_v_o=0, all resp_* fields=0, received_o=0, sent_o=0, error_o=0, req_ready_o=0.
- Response buffer: 2-entry FIFO.
  - req_ready_o = en_i & ~full. It is combinational from registered state only; it must not depend on req_v_i or resp_yumi_i.
- Latency: a request accepted in cycle N produces resp_v_o=1 in cycle N+1.
  - Response fields are registered FIFO head outputs; they stay stable while resp_v_o=1 and resp_yumi_i=0.
- Request decode, where range ok = req_addr_i < 2^lg_mem_els_p:
  - load, range ok: type 0, data = mem[addr].
  - store, range ok: mem[addr] <= data at the accept edge; type 1, data 0.
  - illegal op or out of range: type 2, data 0, error_o set. Memory is unchanged.
- Read-after-write: a load accepted the cycle after a store to the same address returns the new data.
- Simultaneous enqueue and dequeue:
  - One entry held: both proceed; occupancy stays 1.
  - Full: no accept, because ready=0; a dequeue in that cycle makes ready=1 in the following cycle only.
  - Empty: no bypass; a response always takes 1 cycle.
- Counters: received_o increments on each accept; sent_o increments on each resp_yumi_i. Both are 32-bit and wrap modulo 2^32.
- error_o also sets if resp_yumi_i=1 while resp_v_o=0. error_o clears only on reset.
- en_i deassert: stops new accepts only. Buffered responses still drain.
- Reset assertion mid-operation: buffered responses are discarded immediately and resp_v_o drops asynchronously. There are no partial writes: a store commits only on a clock edge with reset deasserted.

Test Plan:
- Reset with en_i=0 and req_v_i=1 -> req_ready_o=0, resp_v_o=0, counters 0, error_o=0; after release with en_i still 0, nothing is accepted.
- Store addr 3 data 0xDEADBEEF tag 5 src (9,4), then load addr 3 tag 6 -> responses: type 1 tag 5 dest (9,4); then type 0 data 0xDEADBEEF tag 6. received_o=2, sent_o=2.
- Hold resp_yumi_i=0 and issue 3 back-to-back loads -> 2 accepted, req_ready_o=0 on the 3rd. One yumi -> ready returns 1 cycle later; the 3rd load is accepted and responses arrive in order.
- Load addr 16 (out of range), then illegal op 3 -> two type-2 responses with data 0; error_o=1 and stays 1; memory contents are unchanged (verify with a readback).
- Continuous traffic with random yumi gaps for 1000 requests, then en_i=0 and drain -> sent_o == received_o == 1000, error_o=0, and no response reordered.
- Assert reset_n_i with 2 responses buffered -> resp_v_o=0 without a clock edge; after release, loading the previously stored address returns 0.
